sa_output_fifo_bank: RTL and testbench
======================================

# sa_output_fifo_bank

Per-lane output FIFO bank between the systolic array drain and `SA_Data_mover`. Each of the `PE_SIZE` lanes captures one column's results as the array drains, with the array's skew. The data mover then pops them with its staggered per-lane read enables. Reads are first-word-fall-through, so the data mover samples `rdata_o` in the same cycle it asserts `rden_i`.

## Interface
Parameters:
- `FIFO_DATA_WIDTH`, 8, bits per lane entry
- `FIFO_DEPTH`, 16, entries per lane; power of two, ≥ 2
- `PE_SIZE`, 16, number of lanes (array columns)

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `wren_i`  in  `PE_SIZE`  per-lane push strobe from array drain
- `wdata_i`  in  `FIFO_DATA_WIDTH*PE_SIZE`  push data; lane i at bits `[FIFO_DATA_WIDTH*PE_SIZE-1-i*FIFO_DATA_WIDTH -: FIFO_DATA_WIDTH]` (lane 0 in MSBs)
- `rden_i`  in  `PE_SIZE`  per-lane pop strobe from data mover
- `rdata_o`  out  `FIFO_DATA_WIDTH*PE_SIZE`  head entry of each lane, same packing as `wdata_i`
- `empty_o`  out  `PE_SIZE`  lane i holds 0 entries
- `full_o`  out  `PE_SIZE`  lane i holds `FIFO_DEPTH` entries
- `tile_ready_o`  out  1  every lane holds ≥ `PE_SIZE` entries
- `err_clr_i`  in  1  clears sticky error flags
- `overflow_o`  out  `PE_SIZE`  sticky: a push was dropped on lane i
- `underflow_o`  out  `PE_SIZE`  sticky: a pop hit empty lane i

## Operation
- Lanes are fully independent. Each lane has a write pointer, a read pointer, and a count of width `$clog2(FIFO_DEPTH+1)`. Pointers wrap modulo `FIFO_DEPTH`.
- Push (`wren_i[i]`): writes `mem[wptr]` and increments `wptr`.
  - The push is accepted if the lane is not full, or if it is full and `rden_i[i]` is asserted in the same cycle.
  - A push on a full lane without a same-cycle pop is dropped, and `overflow_o[i]` is set.
- Pop (`rden_i[i]`): increments `rptr`.
  - The pop is accepted only when the lane is not empty.
  - A pop on an empty lane is ignored, and `underflow_o[i]` is set.
- Simultaneous push and pop on a non-empty lane: both execute and the count is unchanged.
- Simultaneous push and pop on an empty lane: the push executes, the pop is ignored and is flagged as underflow. There is no bypass.
- `rdata_o` lane i:
  - equals `mem[rptr]` combinationally from registered state when the lane is non-empty;
  - is forced to 0 when the lane is empty.
- `tile_ready_o`: the AND over all lanes of `count ≥ PE_SIZE`, decoded combinationally from the registered counts. The top level requires `FIFO_DEPTH ≥ PE_SIZE`; this is checked by an elaboration-time assertion.
- Sticky flags are cleared by `rst` or `err_clr_i`. If `err_clr_i` and a new error occur in the same cycle, the new error wins and the flag stays set.
- `rst` mid-operation:
  - zeroes all pointers, counts and sticky flags;
  - discards all contents (memory is not cleared, but it becomes unreachable);
  - ignores any push or pop in the reset cycle.

## Timing
- Reset values: `empty_o` all 1; `full_o` 0; `tile_ready_o` 0; `overflow_o`/`underflow_o` 0; `rdata_o` 0.
- Push-to-visible latency: 1 cycle. A push at edge N is visible on `rdata_o` and deasserts `empty_o` after edge N.
- Pop: the data mover samples `rdata_o` during the cycle in which `rden_i[i]` is high. The next entry is presented after that edge. This gives zero-latency FWFT reads.
- Flags (`empty_o`, `full_o`, `tile_ready_o`, errors) all update on the same edge as the count. They have no combinational path from `wren_i`/`rden_i`.
- Sustained throughput is 1 push plus 1 pop per lane per cycle.

## Structure
- Shared package `sa_pkg`:
  - `CNT_WIDTH` and `PTR_WIDTH` localparam functions (`$clog2` based);
  - a lane-slice helper giving the MSB index of lane i, shared with `SA_Data_mover`.
- Sub-module `sa_lane_fifo`: one FWFT synchronous FIFO with count, full/empty and sticky error flags.
  - Instantiated `PE_SIZE` times by a generate loop.
  - The top level adds only lane packing and the `tile_ready_o` reduction.

## Test plan
- Reset, then push 0x01..0x10 on all 16 lanes over 16 cycles (lane i data = 0x10·i+k) → `tile_ready_o` rises after the 16th edge; `full_o` = 0xFFFF.
- Staggered pop (lane i `rden` high cycles i..i+15) → each lane returns its 16 values in order, sampled same-cycle; `empty_o[i]` sets after lane i's last pop; no errors.
- Lane 3 full, push 0xAA without pop → dropped, `overflow_o[3]`=1, count stays 16. Pulse `err_clr_i` → flag clears.
- Lane 5 full, push 0x55 and pop in the same cycle → oldest entry pops, 0x55 becomes the tail, count stays 16, no overflow.
- Pop on empty lane 0 with a simultaneous push of 0x7E → `underflow_o[0]`=1; next cycle `rdata_o` lane 0 = 0x7E and count = 1.
- Fill lanes to 8 entries, assert `rst` for 1 cycle with active pushes and pops → all lanes empty, `rdata_o`=0, flags at reset values.

Source files
------------

// File: rtl/sa_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sa_pkg : shared sizing helpers for the systolic-array data path      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package sa_pkg;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Lane 0 occupies the MSBs of a packed lane bus.
  function automatic int lane_msb(input int lane, input int width, input int lanes);
    return width * lanes - 1 - lane * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sa_lane_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sa_lane_fifo : first-word-fall-through FIFO with sticky error flags  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sa_lane_fifo
  import sa_pkg::*;
#(
  parameter  int FIFO_DATA_WIDTH = 8,
  parameter  int FIFO_DEPTH      = 16,
  localparam int CNT_WIDTH       = cnt_width(FIFO_DEPTH),
  localparam int PTR_WIDTH       = ptr_width(FIFO_DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wren_i,
  input  logic [FIFO_DATA_WIDTH-1:0] wdata_i,
  input  logic                       rden_i,
  input  logic                       err_clr_i,
  output logic [FIFO_DATA_WIDTH-1:0] rdata_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [CNT_WIDTH-1:0]       count_o,
  output logic                       overflow_o,
  output logic                       underflow_o
);

  logic [FIFO_DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]       r_wptr;
  logic [PTR_WIDTH-1:0]       r_rptr;
  logic [CNT_WIDTH-1:0]       r_count;
  logic                       r_ovf;
  logic                       r_unf;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_ovf_evt;
  logic w_unf_evt;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_WIDTH'(FIFO_DEPTH));

  // A full lane still accepts a push when the head leaves in the same cycle.
  assign w_pop     = rden_i & ~w_empty;
  assign w_push    = wren_i & (~w_full | rden_i);
  assign w_ovf_evt = wren_i & w_full & ~rden_i;
  assign w_unf_evt = rden_i & w_empty;

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wptr] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_WIDTH'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_WIDTH'(1);
      r_count <= r_count + CNT_WIDTH'(w_push) - CNT_WIDTH'(w_pop);
      // A fresh error outranks a simultaneous clear.
      if (w_ovf_evt)      r_ovf <= 1'b1;
      else if (err_clr_i) r_ovf <= 1'b0;
      if (w_unf_evt)      r_unf <= 1'b1;
      else if (err_clr_i) r_unf <= 1'b0;
    end
  end

  assign rdata_o     = w_empty ? '0 : r_mem[r_rptr];
  assign empty_o     = w_empty;
  assign full_o      = w_full;
  assign count_o     = r_count;
  assign overflow_o  = r_ovf;
  assign underflow_o = r_unf;

endmodule
`default_nettype wire

// File: rtl/sa_output_fifo_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sa_output_fifo_bank : per-lane FWFT FIFOs between array drain and    |
// | data mover, with tile-ready reduction.  Rev 1.0                      |
// +----------------------------------------------------------------------+
module sa_output_fifo_bank
  import sa_pkg::*;
#(
  parameter int FIFO_DATA_WIDTH = 8,
  parameter int FIFO_DEPTH      = 16,
  parameter int PE_SIZE         = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [PE_SIZE-1:0]                 wren_i,
  input  logic [FIFO_DATA_WIDTH*PE_SIZE-1:0] wdata_i,
  input  logic [PE_SIZE-1:0]                 rden_i,
  output logic [FIFO_DATA_WIDTH*PE_SIZE-1:0] rdata_o,
  output logic [PE_SIZE-1:0]                 empty_o,
  output logic [PE_SIZE-1:0]                 full_o,
  output logic                               tile_ready_o,
  input  logic                               err_clr_i,
  output logic [PE_SIZE-1:0]                 overflow_o,
  output logic [PE_SIZE-1:0]                 underflow_o
);

  localparam int CNT_WIDTH = cnt_width(FIFO_DEPTH);

  if (FIFO_DEPTH < PE_SIZE) begin : g_depth_check
    $error("sa_output_fifo_bank: FIFO_DEPTH must be >= PE_SIZE");
  end

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_pow2_check
    $error("sa_output_fifo_bank: FIFO_DEPTH must be a power of two >= 2");
  end

  logic [PE_SIZE-1:0] w_lane_ready;

  for (genvar i = 0; i < PE_SIZE; i++) begin : g_lane
    localparam int MSB = lane_msb(i, FIFO_DATA_WIDTH, PE_SIZE);
    logic [CNT_WIDTH-1:0] w_count;

    sa_lane_fifo #(
      .FIFO_DATA_WIDTH (FIFO_DATA_WIDTH),
      .FIFO_DEPTH      (FIFO_DEPTH)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .wren_i      (wren_i[i]),
      .wdata_i     (wdata_i[MSB -: FIFO_DATA_WIDTH]),
      .rden_i      (rden_i[i]),
      .err_clr_i   (err_clr_i),
      .rdata_o     (rdata_o[MSB -: FIFO_DATA_WIDTH]),
      .empty_o     (empty_o[i]),
      .full_o      (full_o[i]),
      .count_o     (w_count),
      .overflow_o  (overflow_o[i]),
      .underflow_o (underflow_o[i])
    );

    assign w_lane_ready[i] = (w_count >= CNT_WIDTH'(PE_SIZE));
  end

  assign tile_ready_o = &w_lane_ready;

endmodule
`default_nettype wire

// File: tb/tb_sa_output_fifo_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sa_output_fifo_bank : queue-scoreboard and vector-table bench     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_sa_output_fifo_bank;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int PE = 16;
  localparam int BW = W * PE;

  logic          clk = 1'b0;
  logic          rst;
  logic [PE-1:0] wren_i;
  logic [BW-1:0] wdata_i;
  logic [PE-1:0] rden_i;
  logic [BW-1:0] rdata_o;
  logic [PE-1:0] empty_o;
  logic [PE-1:0] full_o;
  logic          tile_ready_o;
  logic          err_clr_i;
  logic [PE-1:0] overflow_o;
  logic [PE-1:0] underflow_o;

  sa_output_fifo_bank #(
    .FIFO_DATA_WIDTH (W),
    .FIFO_DEPTH      (D),
    .PE_SIZE         (PE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wren_i       (wren_i),
    .wdata_i      (wdata_i),
    .rden_i       (rden_i),
    .rdata_o      (rdata_o),
    .empty_o      (empty_o),
    .full_o       (full_o),
    .tile_ready_o (tile_ready_o),
    .err_clr_i    (err_clr_i),
    .overflow_o   (overflow_o),
    .underflow_o  (underflow_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: one expected-data queue per lane plus expected sticky flags.
  logic [W-1:0]  mq [PE][$];
  logic [PE-1:0] m_ovf;
  logic [PE-1:0] m_unf;

  typedef struct {
    string         name;
    logic [PE-1:0] wr;
    logic [BW-1:0] wd;
    logic [PE-1:0] rd;
    logic          clr;
    logic [PE-1:0] e_empty;
    logic [PE-1:0] e_full;
    logic [PE-1:0] e_ovf;
    logic [PE-1:0] e_unf;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] lane_word(input int lane, input logic [W-1:0] val);
    logic [BW-1:0] r;
    r = '0;
    r[BW-1-lane*W -: W] = val;
    return r;
  endfunction

  function automatic logic [W-1:0] lane_of(input logic [BW-1:0] bus, input int lane);
    return bus[BW-1-lane*W -: W];
  endfunction

  task automatic model_update(input logic [PE-1:0] wr, input logic [BW-1:0] wd,
                              input logic [PE-1:0] rd, input logic clr, input logic rs);
    for (int i = 0; i < PE; i++) begin
      if (rs) begin
        mq[i].delete();
        m_ovf[i] = 1'b0;
        m_unf[i] = 1'b0;
      end else begin
        bit was_full;
        bit was_empty;
        was_full  = (mq[i].size() == D);
        was_empty = (mq[i].size() == 0);
        if (wr[i] && was_full && !rd[i]) m_ovf[i] = 1'b1;
        else if (clr)                    m_ovf[i] = 1'b0;
        if (rd[i] && was_empty)          m_unf[i] = 1'b1;
        else if (clr)                    m_unf[i] = 1'b0;
        if (rd[i] && !was_empty) void'(mq[i].pop_front());
        if (wr[i] && (!was_full || rd[i])) mq[i].push_back(lane_of(wd, i));
      end
    end
  endtask

  task automatic check_state(input string tag);
    logic [BW-1:0] e_rdata;
    logic [PE-1:0] e_empty;
    logic [PE-1:0] e_full;
    logic          e_tile;
    e_rdata = '0;
    e_tile  = 1'b1;
    for (int i = 0; i < PE; i++) begin
      e_empty[i] = (mq[i].size() == 0);
      e_full[i]  = (mq[i].size() == D);
      if (mq[i].size() < PE) e_tile = 1'b0;
      if (mq[i].size() != 0) e_rdata[BW-1-i*W -: W] = mq[i][0];
    end
    chk({tag, ".rdata"}, rdata_o, e_rdata);
    chk({tag, ".empty"}, BW'(empty_o), BW'(e_empty));
    chk({tag, ".full"},  BW'(full_o),  BW'(e_full));
    chk({tag, ".tile"},  BW'(tile_ready_o), BW'(e_tile));
    chk({tag, ".ovf"},   BW'(overflow_o),  BW'(m_ovf));
    chk({tag, ".unf"},   BW'(underflow_o), BW'(m_unf));
  endtask

  // Drive one cycle of stimulus, advance one edge, update the scoreboard, compare.
  task automatic step(input string tag, input logic [PE-1:0] wr, input logic [BW-1:0] wd,
                      input logic [PE-1:0] rd, input logic clr, input logic rs);
    wren_i    = wr;
    wdata_i   = wd;
    rden_i    = rd;
    err_clr_i = clr;
    rst       = rs;
    @(posedge clk);
    #1;
    model_update(wr, wd, rd, clr, rs);
    wren_i    = '0;
    wdata_i   = '0;
    rden_i    = '0;
    err_clr_i = 1'b0;
    rst       = 1'b0;
    check_state(tag);
  endtask

  initial begin
    logic [BW-1:0] wd;
    logic [PE-1:0] rd;

    tbl[0] = '{"ovf3",        16'h0008, lane_word(3, 8'hAA), 16'h0000, 1'b0,
               16'hFFD7, 16'h0028, 16'h0008, 16'h0000};
    tbl[1] = '{"clr_ovf",     16'h0000, '0,                  16'h0000, 1'b1,
               16'hFFD7, 16'h0028, 16'h0000, 16'h0000};
    tbl[2] = '{"full_pushpop5", 16'h0020, lane_word(5, 8'h55), 16'h0020, 1'b0,
               16'hFFD7, 16'h0028, 16'h0000, 16'h0000};
    tbl[3] = '{"unf0_push",   16'h0001, lane_word(0, 8'h7E), 16'h0001, 1'b0,
               16'hFFD6, 16'h0028, 16'h0000, 16'h0001};
    tbl[4] = '{"clr_vs_new",  16'h0000, '0,                  16'h0002, 1'b1,
               16'hFFD6, 16'h0028, 16'h0000, 16'h0002};
    tbl[5] = '{"clr_unf",     16'h0000, '0,                  16'h0000, 1'b1,
               16'hFFD6, 16'h0028, 16'h0000, 16'h0000};

    m_ovf = '0;
    m_unf = '0;
    wren_i = '0; wdata_i = '0; rden_i = '0; err_clr_i = 1'b0; rst = 1'b1;

    step("reset0", '0, '0, '0, 1'b0, 1'b1);
    step("reset1", '0, '0, '0, 1'b0, 1'b1);
    chk("rst_empty", BW'(empty_o), BW'(16'hFFFF));
    chk("rst_full",  BW'(full_o),  '0);
    chk("rst_rdata", rdata_o, '0);
    chk("rst_tile",  BW'(tile_ready_o), '0);

    // Fill all lanes: lane i, push k carries 0x10*i + k.
    for (int k = 1; k <= D; k++) begin
      wd = '0;
      for (int i = 0; i < PE; i++) wd[BW-1-i*W -: W] = W'(16 * i + k);
      step("fill", '1, wd, '0, 1'b0, 1'b0);
      if (k == D - 1) chk("tile_before_last", BW'(tile_ready_o), '0);
    end
    chk("tile_after_fill", BW'(tile_ready_o), BW'(1'b1));
    chk("full_after_fill", BW'(full_o), BW'(16'hFFFF));
    chk("lane0_head", BW'(lane_of(rdata_o, 0)), BW'(8'h01));
    chk("lane7_head", BW'(lane_of(rdata_o, 7)), BW'(8'h71));

    // Staggered drain: lane i pops on cycles i..i+15.
    for (int c = 0; c < D + PE - 1; c++) begin
      rd = '0;
      for (int i = 0; i < PE; i++) if (c >= i && c <= i + D - 1) rd[i] = 1'b1;
      step("stagger", '0, '0, rd, 1'b0, 1'b0);
      if (c == D - 1) chk("lane0_empty_after_last", BW'(empty_o[0]), BW'(1'b1));
    end
    chk("drain_empty", BW'(empty_o), BW'(16'hFFFF));
    chk("drain_noerr", BW'({overflow_o, underflow_o}), '0);

    // Fill lanes 3 and 5 only.
    for (int k = 1; k <= D; k++)
      step("fill35", 16'h0028, lane_word(3, W'(k)) | lane_word(5, W'(8'h80 + k)),
           '0, 1'b0, 1'b0);

    for (int v = 0; v < 6; v++) begin
      step(tbl[v].name, tbl[v].wr, tbl[v].wd, tbl[v].rd, tbl[v].clr, 1'b0);
      chk({tbl[v].name, ".v_empty"}, BW'(empty_o),     BW'(tbl[v].e_empty));
      chk({tbl[v].name, ".v_full"},  BW'(full_o),      BW'(tbl[v].e_full));
      chk({tbl[v].name, ".v_ovf"},   BW'(overflow_o),  BW'(tbl[v].e_ovf));
      chk({tbl[v].name, ".v_unf"},   BW'(underflow_o), BW'(tbl[v].e_unf));
    end
    chk("lane0_7E", BW'(lane_of(rdata_o, 0)), BW'(8'h7E));
    chk("lane5_head_after_pushpop", BW'(lane_of(rdata_o, 5)), BW'(8'h82));

    step("drain035", '0, '0, 16'h0029, 1'b0, 1'b0);
    for (int k = 0; k < D - 2; k++) step("drain35", '0, '0, 16'h0028, 1'b0, 1'b0);
    chk("lane5_tail_55", BW'(lane_of(rdata_o, 5)), BW'(8'h55));
    step("drain35_last", '0, '0, 16'h0028, 1'b0, 1'b0);
    chk("corner_empty", BW'(empty_o), BW'(16'hFFFF));
    chk("corner_noerr", BW'({overflow_o, underflow_o}), '0);

    // Mid-operation reset with active pushes and pops.
    for (int k = 0; k < 8; k++) begin
      wd = '0;
      for (int i = 0; i < PE; i++) wd[BW-1-i*W -: W] = W'($urandom_range(255));
      step("fill8", '1, wd, '0, 1'b0, 1'b0);
    end
    step("rst_mid", '1, {BW{1'b1}}, '1, 1'b0, 1'b1);
    chk("rst_mid_empty", BW'(empty_o), BW'(16'hFFFF));
    chk("rst_mid_rdata", rdata_o, '0);
    chk("rst_mid_full",  BW'(full_o), '0);
    chk("rst_mid_flags", BW'({tile_ready_o, overflow_o, underflow_o}), '0);
    step("post_rst", 16'h8001, lane_word(0, 8'h3C) | lane_word(15, 8'hC3), '0, 1'b0, 1'b0);
    chk("post_rst_lane15", BW'(lane_of(rdata_o, 15)), BW'(8'hC3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
